// File: rtl/id_pkg.sv
// Shared definitions for the instruction decode stage: field positions,
// opcode encodings, the decoded control bundle and the source/destination rules.
package id_pkg;

  localparam int DATA_W = 32;
  localparam int NREGS  = 8;
  localparam int IMM_W  = 16;
  localparam int REG_W  = 3;

  localparam int FIRST_LD_LSB  = 30;
  localparam int SPECIAL_BIT   = 29;
  localparam int SECOND_LD_LSB = 25;
  localparam int ALU_OC_LSB    = 22;
  localparam int B_COND_LSB    = 18;
  localparam int DEST_LSB      = 19;
  localparam int PTR_LSB       = 16;
  localparam int SRC2_LSB      = 13;
  localparam int IMM_LSB       = 0;

  typedef enum logic [1:0] {
    FL_DATA   = 2'b00,
    FL_CLS1   = 2'b01,
    FL_CLS2   = 2'b10,
    FL_BRANCH = 2'b11
  } first_ld_e;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b001,
    ALU_SUB = 3'b010,
    ALU_AND = 3'b011,
    ALU_OR  = 3'b100,
    ALU_XOR = 3'b101,
    ALU_NOT = 3'b110
  } alu_oc_e;

  typedef enum logic [2:0] {
    OP_MOV  = 3'b000,
    OP_MOVT = 3'b001,
    OP_CLR  = 3'b010,
    OP_SET  = 3'b011,
    OP_LSL  = 3'b100,
    OP_LSR  = 3'b101
  } misc_oc_e;

  typedef struct packed {
    logic [1:0]       first_ld;
    logic             special;
    logic [3:0]       second_ld;
    logic [2:0]       alu_oc;
    logic [3:0]       b_cond;
    logic [REG_W-1:0] dest_reg;
    logic [REG_W-1:0] pointer_reg;
    logic [IMM_W-1:0] imm;
  } ctrl_t;

  function automatic ctrl_t decode(input logic [31:0] instr);
    ctrl_t c;
    c.first_ld    = instr[FIRST_LD_LSB +: 2];
    c.special     = instr[SPECIAL_BIT];
    c.second_ld   = instr[SECOND_LD_LSB +: 4];
    c.alu_oc      = instr[ALU_OC_LSB +: 3];
    c.b_cond      = instr[B_COND_LSB +: 4];
    c.dest_reg    = instr[DEST_LSB +: REG_W];
    c.pointer_reg = instr[PTR_LSB +: REG_W];
    c.imm         = instr[IMM_LSB +: IMM_W];
    return c;
  endfunction

  // In the non-special class the alu_oc field carries the misc opcode.
  function automatic logic uses_op1(input ctrl_t c);
    return c.special ||
           (c.first_ld == FL_DATA && c.alu_oc inside {OP_MOVT, OP_LSL, OP_LSR});
  endfunction

  function automatic logic uses_op2(input ctrl_t c);
    return c.special && c.first_ld[0] && (c.alu_oc != ALU_NOT);
  endfunction

  function automatic logic writes_dest(input ctrl_t c);
    if (c.special)
      return c.alu_oc inside {[ALU_ADD:ALU_NOT]};
    return (c.first_ld == FL_DATA) && (c.alu_oc <= OP_LSR);
  endfunction

endpackage

// File: rtl/id_scoreboard.sv
// Pending-write scoreboard: one busy bit per register, set on accepted writers,
// cleared on writeback, and undone for a bundle discarded by flush.
module id_scoreboard
  import id_pkg::*;
#(
  parameter int NREGS = id_pkg::NREGS
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             accept,
  input  logic             writes_dest,
  input  logic [REG_W-1:0] set_reg,
  input  logic             wb_valid,
  input  logic [REG_W-1:0] wb_reg,
  input  logic             flush,
  input  logic             bundle_valid,
  input  logic [REG_W-1:0] rs1,
  input  logic [REG_W-1:0] rs2,
  input  logic             uses_op1,
  input  logic             uses_op2,
  output logic             hazard
);

  logic [NREGS-1:0] busy, busy_nxt;
  logic [REG_W-1:0] last_reg;
  logic             last_valid;
  logic             set_en, undo;

  assign set_en = accept && writes_dest;
  // last_reg names the rd of the bundle currently held, if it set a busy bit.
  assign undo   = flush && bundle_valid && last_valid;

  // NOTE: every bit gets its current value first, so no path leaves busy_nxt
  // unassigned and no latch is inferred; later lines override earlier ones,
  // which is how "set wins over clear" is expressed.
  always_comb begin
    busy_nxt = busy;
    if (undo)     busy_nxt[last_reg] = 1'b0;
    if (wb_valid) busy_nxt[wb_reg]   = 1'b0;
    if (set_en)   busy_nxt[set_reg]  = 1'b1;
  end

  // NOTE: state updates use non-blocking assignments so every register samples
  // the pre-edge values; reset is synchronous and sampled on the clock edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy       <= '0;
      last_reg   <= '0;
      last_valid <= 1'b0;
    end else begin
      busy <= busy_nxt;
      if (set_en) begin
        last_reg   <= set_reg;
        last_valid <= 1'b1;
      end else if (accept || flush) begin
        last_valid <= 1'b0;
      end
    end
  end

  assign hazard = (uses_op1 && busy[rs1]) || (uses_op2 && busy[rs2]);

endmodule

// File: rtl/id_stage.sv
// Instruction decode stage: splits fetch words into execute control fields,
// reads operands with writeback bypass, and stalls on pending register writes.
module id_stage
  import id_pkg::*;
#(
  parameter int DATA_W = id_pkg::DATA_W,
  parameter int NREGS  = id_pkg::NREGS,
  parameter int IMM_W  = id_pkg::IMM_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_valid,
  input  logic [31:0]       if_instr,
  output logic              if_ready,
  input  logic              flush,
  output logic [REG_W-1:0]  rf_raddr1,
  output logic [REG_W-1:0]  rf_raddr2,
  input  logic [DATA_W-1:0] rf_rdata1,
  input  logic [DATA_W-1:0] rf_rdata2,
  input  logic              wb_valid,
  input  logic [REG_W-1:0]  wb_reg,
  input  logic [DATA_W-1:0] wb_data,
  output logic              ex_valid,
  input  logic              ex_ready,
  output logic [1:0]        ex_first_ld,
  output logic              ex_special,
  output logic [3:0]        ex_second_ld,
  output logic [2:0]        ex_alu_oc,
  output logic [3:0]        ex_b_cond,
  output logic [REG_W-1:0]  ex_dest_reg,
  output logic [REG_W-1:0]  ex_pointer_reg,
  output logic [DATA_W-1:0] ex_op1,
  output logic [DATA_W-1:0] ex_op2,
  output logic [IMM_W-1:0]  ex_imm,
  output logic [IMM_W-1:0]  ex_offset
);

  ctrl_t             dec, ex_ctrl;
  logic [REG_W-1:0]  rs2;
  logic              use1, use2, wr_dest, hazard, accept;
  logic [DATA_W-1:0] op1_d, op2_d;

  assign dec     = decode(if_instr);
  assign rs2     = if_instr[SRC2_LSB +: REG_W];
  assign use1    = uses_op1(dec);
  assign use2    = uses_op2(dec);
  assign wr_dest = writes_dest(dec);

  assign rf_raddr1 = dec.pointer_reg;
  assign rf_raddr2 = rs2;

  assign if_ready = rst_n && !hazard && (!ex_valid || ex_ready);
  assign accept   = if_valid && if_ready && !flush;

  id_scoreboard #(.NREGS(NREGS)) u_scoreboard (
    .clk          (clk),
    .rst_n        (rst_n),
    .accept       (accept),
    .writes_dest  (wr_dest),
    .set_reg      (dec.dest_reg),
    .wb_valid     (wb_valid),
    .wb_reg       (wb_reg),
    .flush        (flush),
    .bundle_valid (ex_valid),
    .rs1          (dec.pointer_reg),
    .rs2          (rs2),
    .uses_op1     (use1),
    .uses_op2     (use2),
    .hazard       (hazard)
  );

  // Unused operands are zeroed; a same-cycle writeback overrides the RF read.
  always_comb begin
    op1_d = '0;
    op2_d = '0;
    if (use1) op1_d = (wb_valid && wb_reg == dec.pointer_reg) ? wb_data : rf_rdata1;
    if (use2) op2_d = (wb_valid && wb_reg == rs2) ? wb_data : rf_rdata2;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ex_valid <= 1'b0;
      ex_ctrl  <= '0;
      ex_op1   <= '0;
      ex_op2   <= '0;
    end else if (accept) begin
      ex_valid <= 1'b1;
      ex_ctrl  <= dec;
      ex_op1   <= op1_d;
      ex_op2   <= op2_d;
    end else if (flush || ex_ready) begin
      ex_valid <= 1'b0;
    end
  end

  assign ex_first_ld    = ex_ctrl.first_ld;
  assign ex_special     = ex_ctrl.special;
  assign ex_second_ld   = ex_ctrl.second_ld;
  assign ex_alu_oc      = ex_ctrl.alu_oc;
  assign ex_b_cond      = ex_ctrl.b_cond;
  assign ex_dest_reg    = ex_ctrl.dest_reg;
  assign ex_pointer_reg = ex_ctrl.pointer_reg;
  assign ex_imm         = ex_ctrl.imm;
  assign ex_offset      = ex_ctrl.imm;

endmodule

// File: tb/tb_id_stage.sv
// Directed bench for id_stage: expected bundles are queued at issue time and
// a monitor compares each bundle execute consumes.
module tb_id_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_valid;
  logic [31:0] if_instr;
  logic        if_ready;
  logic        flush;
  logic [2:0]  rf_raddr1, rf_raddr2;
  logic [31:0] rf_rdata1, rf_rdata2;
  logic        wb_valid;
  logic [2:0]  wb_reg;
  logic [31:0] wb_data;
  logic        ex_valid;
  logic        ex_ready;
  logic [1:0]  ex_first_ld;
  logic        ex_special;
  logic [3:0]  ex_second_ld;
  logic [2:0]  ex_alu_oc;
  logic [3:0]  ex_b_cond;
  logic [2:0]  ex_dest_reg, ex_pointer_reg;
  logic [31:0] ex_op1, ex_op2;
  logic [15:0] ex_imm, ex_offset;

  logic [31:0]  rf [8];
  logic [115:0] exp_q [$];
  logic [115:0] got;
  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  assign rf_rdata1 = rf[rf_raddr1];
  assign rf_rdata2 = rf[rf_raddr2];
  assign got = {ex_first_ld, ex_special, ex_second_ld, ex_alu_oc, ex_b_cond,
                ex_dest_reg, ex_pointer_reg, ex_op1, ex_op2, ex_imm, ex_offset};

  id_stage dut (
    .clk(clk), .rst_n(rst_n), .if_valid(if_valid), .if_instr(if_instr),
    .if_ready(if_ready), .flush(flush), .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2),
    .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2), .wb_valid(wb_valid), .wb_reg(wb_reg),
    .wb_data(wb_data), .ex_valid(ex_valid), .ex_ready(ex_ready),
    .ex_first_ld(ex_first_ld), .ex_special(ex_special), .ex_second_ld(ex_second_ld),
    .ex_alu_oc(ex_alu_oc), .ex_b_cond(ex_b_cond), .ex_dest_reg(ex_dest_reg),
    .ex_pointer_reg(ex_pointer_reg), .ex_op1(ex_op1), .ex_op2(ex_op2),
    .ex_imm(ex_imm), .ex_offset(ex_offset)
  );

  task automatic check(input bit ok, input string name,
                       input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] enc(input logic [1:0] fl, input logic sp,
                                      input logic [3:0] sl, input logic [2:0] oc,
                                      input logic [2:0] rd, input logic [2:0] rs1,
                                      input logic [15:0] low);
    return {fl, sp, sl, oc, rd, rs1, low};
  endfunction

  // Expected bundle: field slices of the word plus hand-computed operands.
  function automatic logic [115:0] mk(input logic [31:0] ins, input logic [31:0] o1,
                                      input logic [31:0] o2);
    return {ins[31:30], ins[29], ins[28:25], ins[24:22], ins[21:18], ins[21:19],
            ins[18:16], o1, o2, ins[15:0], ins[15:0]};
  endfunction

  // Called at posedge+1; returns at posedge+1 after the accept edge.
  task automatic send(input logic [31:0] ins, input logic [31:0] o1, input logic [31:0] o2,
                      input bit push, input bit ready_now, input string nm);
    int n = 0;
    if_instr = ins;
    if_valid = 1'b1;
    @(negedge clk);
    if (ready_now) check(if_ready === 1'b1, {nm, "_ready"}, if_ready, 1);
    while (if_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check(if_ready === 1'b1, {nm, "_accept"}, if_ready, 1);
    if (push) exp_q.push_back(mk(ins, o1, o2));
    @(posedge clk);
    #1 if_valid = 1'b0;
  endtask

  task automatic writeback(input logic [2:0] r);
    wb_valid = 1'b1;
    wb_reg   = r;
    wb_data  = 32'h0;
    @(posedge clk);
    #1 wb_valid = 1'b0;
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1 && ex_valid === 1'b1 && ex_ready === 1'b1 && flush === 1'b0) begin
      if (exp_q.size() == 0) check(1'b0, "unexpected_bundle", got, 0);
      else begin
        logic [115:0] e;
        e = exp_q.pop_front();
        check(got === e, "bundle", got, e);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] i_add, i_sub, i_mov6, i_xor7, i_and3, i_mov4, i_clr0, i_rd4;
    logic [31:0] i_br, i_rd5, i_mov1, i_rd1;
    i_add  = enc(2'b01, 1'b1, 4'h0, 3'b001, 3'd1, 3'd2, {3'd3, 13'd0});
    i_sub  = enc(2'b01, 1'b1, 4'h0, 3'b010, 3'd5, 3'd1, {3'd3, 13'd0});
    i_mov6 = enc(2'b00, 1'b0, 4'h0, 3'b000, 3'd6, 3'd0, 16'h1234);
    i_xor7 = enc(2'b00, 1'b0, 4'h0, 3'b101, 3'd7, 3'd2, 16'h0000);
    i_and3 = enc(2'b01, 1'b1, 4'h0, 3'b011, 3'd3, 3'd2, {3'd4, 13'd0});
    i_mov4 = enc(2'b00, 1'b0, 4'h0, 3'b000, 3'd4, 3'd0, 16'h0044);
    i_clr0 = enc(2'b00, 1'b0, 4'h0, 3'b010, 3'd0, 3'd0, 16'h0BAD);
    i_rd4  = enc(2'b00, 1'b0, 4'h0, 3'b100, 3'd0, 3'd4, 16'h0000);
    i_br   = enc(2'b11, 1'b0, 4'h0, 3'b000, 3'b101, 3'b011, 16'hFFF0);
    i_rd5  = enc(2'b00, 1'b0, 4'h0, 3'b001, 3'd0, 3'd5, 16'h0000);
    i_mov1 = enc(2'b00, 1'b0, 4'h0, 3'b011, 3'd1, 3'd0, 16'h7777);
    i_rd1  = enc(2'b00, 1'b0, 4'h0, 3'b100, 3'd2, 3'd1, 16'h0000);

    foreach (rf[i]) rf[i] = 32'h0;
    rf[2] = 32'd5; rf[3] = 32'd7; rf[4] = 32'h44; rf[5] = 32'h55;
    rst_n = 1'b0; if_valid = 1'b0; if_instr = 32'h0; flush = 1'b0;
    wb_valid = 1'b0; wb_reg = 3'd0; wb_data = 32'h0; ex_ready = 1'b1;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check(if_ready === 1'b0, "reset_if_ready", if_ready, 0);
    check(ex_valid === 1'b0, "reset_ex_valid", ex_valid, 0);
    check(got === '0, "reset_outputs", got, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // ADD r1 <- r2, r3
    send(i_add, 32'd5, 32'd7, 1, 1, "add");

    // SUB reads r1 while its write is pending
    if_instr = i_sub;
    if_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check(if_ready === 1'b0, "raw_stall", if_ready, 0);
    end
    @(posedge clk);
    #1 wb_valid = 1'b1; wb_reg = 3'd1; wb_data = 32'h111;
    @(negedge clk);
    check(if_ready === 1'b0, "stall_in_wb_cycle", if_ready, 0);
    @(posedge clk);
    #1 wb_valid = 1'b0; rf[1] = 32'h111;
    @(negedge clk);
    check(if_ready === 1'b1, "ready_after_wb", if_ready, 1);
    exp_q.push_back(mk(i_sub, 32'h111, 32'd7));
    @(posedge clk);
    #1 if_valid = 1'b0;

    // Backpressure from execute
    @(posedge clk);
    #1 ex_ready = 1'b0;
    send(i_mov6, 32'h0, 32'h0, 1, 1, "mov6");
    if_instr = i_xor7;
    if_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check(if_ready === 1'b0, "backpressure_stall", if_ready, 0);
      check(ex_valid === 1'b1 && got === mk(i_mov6, 0, 0), "hold_bundle", got, mk(i_mov6, 0, 0));
    end
    @(posedge clk);
    #1 ex_ready = 1'b1;
    @(negedge clk);
    check(if_ready === 1'b1, "ready_on_consume", if_ready, 1);
    exp_q.push_back(mk(i_xor7, 32'd5, 32'h0));
    @(posedge clk);
    #1 if_valid = 1'b0;

    // Writeback bypass into the accepting instruction
    rf[2] = 32'h0;
    if_instr = i_and3; if_valid = 1'b1;
    wb_valid = 1'b1; wb_reg = 3'd2; wb_data = 32'hDEADBEEF;
    @(negedge clk);
    check(if_ready === 1'b1, "bypass_ready", if_ready, 1);
    exp_q.push_back(mk(i_and3, 32'hDEADBEEF, 32'h44));
    @(posedge clk);
    #1 if_valid = 1'b0; wb_valid = 1'b0; rf[2] = 32'hDEADBEEF;

    // Flush discards held MOV r4 and the incoming word, and frees r4
    @(posedge clk);
    #1 ex_ready = 1'b0;
    send(i_mov4, 32'h0, 32'h0, 0, 1, "mov4");
    flush = 1'b1; ex_ready = 1'b1; if_instr = i_clr0; if_valid = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0; if_valid = 1'b0;
    @(negedge clk);
    check(ex_valid === 1'b0, "flush_drops_bundle", ex_valid, 0);
    @(posedge clk);
    #1 send(i_rd4, 32'h44, 32'h0, 1, 1, "rd4_after_flush");

    // Retire outstanding writers, then the branch word
    writeback(3'd0); writeback(3'd3); writeback(3'd5); writeback(3'd6); writeback(3'd7);
    send(i_br, 32'h0, 32'h0, 1, 1, "branch");
    send(i_rd5, 32'h55, 32'h0, 1, 1, "rd5_after_branch");

    // Reset while a writer is held
    @(posedge clk);
    #1 ex_ready = 1'b0;
    send(i_mov1, 32'h0, 32'h0, 0, 1, "mov1");
    rst_n = 1'b0;
    @(negedge clk);
    check(if_ready === 1'b0, "midrst_if_ready", if_ready, 0);
    @(posedge clk);
    #1 rst_n = 1'b1; ex_ready = 1'b1;
    @(negedge clk);
    check(ex_valid === 1'b0 && got === '0, "midrst_clear", got, 0);
    @(posedge clk);
    #1 send(i_rd1, 32'h111, 32'h0, 1, 1, "rd1_after_reset");

    repeat (3) @(posedge clk);
    check(exp_q.size() == 0, "queue_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
